// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment scanner with a double-buffered digit register.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank zero digits above the highest nonzero one).
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned HEX_MODE    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int unsigned CNT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_W-1:0]     disp_q;
    logic [NUM_DIGITS-1:0] disp_dp_q;
    logic [DATA_W-1:0]     pend_q;
    logic [NUM_DIGITS-1:0] pend_dp_q;
    logic                  pend_flag_q;

    logic                  tick_c;
    logic                  wrap_c;
    logic [3:0]            nib_c;
    logic                  dp_c;
    logic                  blank_c;
    logic [6:0]            glyph_c;

    // Digit code to active-low g..a pattern; codes above 9 blank when hex glyphs are off.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        if (HEX_MODE == 0 && code > 4'd9) begin
            g = 7'b1111111;
        end
        return g;
    endfunction

    // Prescaler tick and frame-wrap detection; both are gated by enable so a frozen scan never advances.
    always_comb begin
        tick_c = enable && (cnt_q == CNT_W'(REFRESH_DIV - 1));
        wrap_c = tick_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
    end

    // Selected digit decode, including optional leading-zero suppression.
    always_comb begin
        nib_c   = disp_q[{idx_q, 2'b00} +: 4];
        dp_c    = disp_dp_q[idx_q];
        blank_c = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank_c = (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
`else
        blank_c = 1'b0;
`endif
        glyph_c = blank_c ? 7'b1111111 : glyph(nib_c);
    end

    // Scan position state: prescaler and digit index advance only while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (enable) begin
            if (tick_c) begin
                cnt_q <= '0;
                idx_q <= wrap_c ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Double buffer: loads land in pending; the display copies pending only at a frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q      <= '0;
            disp_dp_q   <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_flag_q <= 1'b0;
        end else begin
            if (wrap_c && pend_flag_q) begin
                disp_q    <= pend_q;
                disp_dp_q <= pend_dp_q;
            end
            if (load) begin
                pend_q      <= digits_in;
                pend_dp_q   <= dp_in;
                pend_flag_q <= 1'b1;
            end else if (wrap_c) begin
                pend_flag_q <= 1'b0;
            end
        end
    end

    // Registered display drive; everything blanks while scanning is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= 8'hFF;
            an_out     <= '1;
            frame_done <= 1'b0;
        end else if (enable) begin
            seg_out    <= {~dp_c, glyph_c};
            an_out     <= ~(NUM_DIGITS'(1) << idx_q);
            frame_done <= wrap_c;
        end else begin
            seg_out    <= 8'hFF;
            an_out     <= '1;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4, HEX_MODE=1).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [7:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] ZB = 8'hFF;
`else
    localparam logic [7:0] ZB = 8'hC0;
`endif

    typedef struct {
        string       name;
        logic        en;
        logic        ld;
        logic [15:0] dig;
        logic [3:0]  dp;
        int          ncyc;
        logic [7:0]  seg;
        logic [3:0]  an;
        logic        fd;
    } vec_t;

    vec_t tbl[$];

    seg7_scan_driver #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .HEX_MODE   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .seg_out   (seg_out),
        .an_out    (an_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [7:0] seg, input logic [3:0] an, input logic fd);
        chk({name, ".seg"}, seg_out, seg);
        chk({name, ".an"}, {4'h0, an_out}, {4'h0, an});
        chk({name, ".fd"}, {7'h0, frame_done}, {7'h0, fd});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string name, input logic en, input logic ld, input logic [15:0] dig,
                       input logic [3:0] dp, input int ncyc, input logic [7:0] seg,
                       input logic [3:0] an, input logic fd);
        vec_t v;
        v.name = name; v.en = en; v.ld = ld; v.dig = dig; v.dp = dp;
        v.ncyc = ncyc; v.seg = seg; v.an = an; v.fd = fd;
        tbl.push_back(v);
    endtask

    initial begin
        int fd_cnt;
        // Edge numbers E count enabled clock edges after reset release.
        add("e1_first",      1, 0, 16'h0000, 4'h0,  1, 8'hC0, 4'b1110, 0);
        add("e4_dig0_end",   1, 0, 16'h0000, 4'h0,  3, 8'hC0, 4'b1110, 0);
        add("e5_dig1",       1, 0, 16'h0000, 4'h0,  1, ZB,    4'b1101, 0);
        add("e9_dig2",       1, 0, 16'h0000, 4'h0,  4, ZB,    4'b1011, 0);
        add("e13_dig3",      1, 0, 16'h0000, 4'h0,  4, ZB,    4'b0111, 0);
        add("e16_wrap",      1, 0, 16'h0000, 4'h0,  3, ZB,    4'b0111, 1);
        add("e17_after",     1, 0, 16'h0000, 4'h0,  1, 8'hC0, 4'b1110, 0);
        add("e19_ld12af",    1, 1, 16'h12AF, 4'h4,  2, 8'hC0, 4'b1110, 0);
        add("e32_wrap_old",  1, 0, 16'h0000, 4'h0, 13, ZB,    4'b0111, 1);
        add("e33_F_dig0",    1, 0, 16'h0000, 4'h0,  1, 8'h8E, 4'b1110, 0);
        add("e37_A_dig1",    1, 0, 16'h0000, 4'h0,  4, 8'h88, 4'b1101, 0);
        add("e41_2dp_dig2",  1, 0, 16'h0000, 4'h0,  4, 8'h24, 4'b1011, 0);
        add("e45_1_dig3",    1, 0, 16'h0000, 4'h0,  4, 8'hF9, 4'b0111, 0);
        add("e46_ld2222",    1, 1, 16'h2222, 4'h0,  1, 8'hF9, 4'b0111, 0);
        add("e47",           1, 0, 16'h0000, 4'h0,  1, 8'hF9, 4'b0111, 0);
        add("e48_ld1111_wr", 1, 1, 16'h1111, 4'h0,  1, 8'hF9, 4'b0111, 1);
        add("e49_show2222",  1, 0, 16'h0000, 4'h0,  1, 8'hA4, 4'b1110, 0);
        add("e64_wrap",      1, 0, 16'h0000, 4'h0, 15, 8'hA4, 4'b0111, 1);
        add("e65_show1111",  1, 0, 16'h0000, 4'h0,  1, 8'hF9, 4'b1110, 0);
        add("e81_still1111", 1, 0, 16'h0000, 4'h0, 16, 8'hF9, 4'b1110, 0);
        add("e90_mid_dig2",  1, 0, 16'h0000, 4'h0,  9, 8'hF9, 4'b1011, 0);
        add("dis_first",     0, 0, 16'h0000, 4'h0,  1, 8'hFF, 4'b1111, 0);
        add("dis_hold",      0, 0, 16'h0000, 4'h0,  9, 8'hFF, 4'b1111, 0);
        add("e91_resume",    1, 0, 16'h0000, 4'h0,  1, 8'hF9, 4'b1011, 0);
        add("e92_dig2_last", 1, 0, 16'h0000, 4'h0,  1, 8'hF9, 4'b1011, 0);
        add("e93_dig3",      1, 0, 16'h0000, 4'h0,  1, 8'hF9, 4'b0111, 0);
        add("dis_ld8765",    0, 1, 16'h8765, 4'h1,  1, 8'hFF, 4'b1111, 0);
        add("e96_wrap",      1, 0, 16'h0000, 4'h0,  3, 8'hF9, 4'b0111, 1);
        add("e97_5dp",       1, 0, 16'h0000, 4'h0,  1, 8'h12, 4'b1110, 0);
        add("e101_6",        1, 0, 16'h0000, 4'h0,  4, 8'h82, 4'b1101, 0);
        add("e105_7",        1, 0, 16'h0000, 4'h0,  4, 8'hF8, 4'b1011, 0);
        add("e109_8",        1, 0, 16'h0000, 4'h0,  4, 8'h80, 4'b0111, 0);
        add("e112_ldEDCB",   1, 1, 16'hEDCB, 4'h0,  3, 8'h80, 4'b0111, 1);
        add("e113_B",        1, 0, 16'h0000, 4'h0,  1, 8'h83, 4'b1110, 0);
        add("e117_C",        1, 0, 16'h0000, 4'h0,  4, 8'hC6, 4'b1101, 0);
        add("e121_D",        1, 0, 16'h0000, 4'h0,  4, 8'hA1, 4'b1011, 0);
        add("e125_E",        1, 0, 16'h0000, 4'h0,  4, 8'h86, 4'b0111, 0);

        rst_n = 1'b0; enable = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;
        repeat (2) step();
        chk_out("reset", 8'hFF, 4'b1111, 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Table: inputs held for ncyc edges (load only on the first), then outputs compared.
        foreach (tbl[k]) begin
            enable    = tbl[k].en;
            load      = tbl[k].ld;
            digits_in = tbl[k].dig;
            dp_in     = tbl[k].dp;
            for (int c = 0; c < tbl[k].ncyc; c++) begin
                step();
                load = 1'b0;
            end
            chk_out(tbl[k].name, tbl[k].seg, tbl[k].an, tbl[k].fd);
        end

        // Asynchronous reset mid-frame with a load pending: outputs clear before the next edge.
        enable = 1'b1; load = 1'b1; digits_in = 16'h9999; dp_in = 4'hF;
        step();
        load = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 8'hFF, 4'b1111, 0);
        step();
        rst_n = 1'b1;

        // Restart at digit 0 with an all-zero display; pending 9999 must never appear.
        step();
        chk_out("rst_restart", 8'hC0, 4'b1110, 0);
        fd_cnt = 0;
        for (int e = 2; e <= 65; e++) begin
            step();
            if (frame_done) fd_cnt++;
            if (e == 17) chk_out("rst_no_pending", 8'hC0, 4'b1110, 0);
        end
        chk("fd_per_16", 8'(fd_cnt), 8'd4);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Leading-zero blanking: restart edge 66 loads 0050, wrap at edge 80.
        load = 1'b1; digits_in = 16'h0050; dp_in = 4'h0;
        step();
        load = 1'b0;
        for (int e = 67; e <= 93; e++) begin
            step();
            if (e == 81) chk_out("lz_d0", 8'hC0, 4'b1110, 0);
            if (e == 85) chk_out("lz_d1", 8'h92, 4'b1101, 0);
            if (e == 89) chk_out("lz_d2", 8'hFF, 4'b1011, 0);
            if (e == 93) chk_out("lz_d3", 8'hFF, 4'b0111, 0);
        end
        load = 1'b1; digits_in = 16'h0000;
        step();
        load = 1'b0;
        for (int e = 95; e <= 101; e++) begin
            step();
            if (e == 97)  chk_out("lz0_d0", 8'hC0, 4'b1110, 0);
            if (e == 101) chk_out("lz0_d1", 8'hFF, 4'b1101, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
